// File: rtl/spm_pkg.sv
// Shared types and elaboration helpers for the serial-parallel multiplier.
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    DONE
  } spm_state_e;

  localparam int unsigned W_MIN = 2;
  localparam int unsigned W_MAX = 32;

  // Bit-step counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/spm_mul_if.sv
// Streaming operand/product port bundle for spm_mul.
interface spm_mul_if #(
  parameter int unsigned W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   mc;
  logic [W-1:0]   mp;
  logic           is_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  modport master (
    output in_valid, mc, mp, is_signed, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, mc, mp, is_signed, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/spm_datapath.sv
// Operand registers, multiplier shift register and shift-right accumulator.
module spm_datapath #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           last_step,
  input  logic [W-1:0]   mc,
  input  logic [W-1:0]   mp,
  input  logic           is_signed,
  output logic [2*W-1:0] p
);
  logic [W-1:0] mc_q;
  logic [W-1:0] mp_sr;
  logic         sgn_q;
  logic [2*W:0] acc;
  logic [W+1:0] hi_x;
  logic [W+1:0] add_x;
  logic [W+1:0] sum;

  // The multiplicand is added into the top W+1 bits and the whole accumulator
  // shifts right each step, so the bit that falls off acc[0] is always zero.
  always_comb begin
    hi_x  = {sgn_q & acc[2*W], acc[2*W:W]};
    add_x = mp_sr[0] ? {{2{sgn_q & mc_q[W-1]}}, mc_q} : '0;
    sum   = (last_step && sgn_q) ? hi_x - add_x : hi_x + add_x;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_q  <= '0;
      mp_sr <= '0;
      sgn_q <= 1'b0;
      acc   <= '0;
    end else if (load) begin
      mc_q  <= mc;
      mp_sr <= mp;
      sgn_q <= is_signed;
      acc   <= '0;
    end else if (step) begin
      acc   <= {sum, acc[W-1:1]};
      mp_sr <= {1'b0, mp_sr[W-1:1]};
    end
  end

  assign p = acc[2*W-1:0];

endmodule

// File: rtl/spm_mul.sv
// Serial-parallel multiplier top: control FSM, bit counter and handshakes.
module spm_mul
  import spm_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic     clk,
  input  logic     rst,
  spm_mul_if.slave bus
);
  localparam int unsigned CW = cnt_width(W);

  generate
    if (W < W_MIN || W > W_MAX) begin : g_bad_width
      $error("spm_mul: W out of supported range");
    end
  endgenerate

  spm_state_e    state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          step;
  logic          last_step;

  // in_ready in DONE follows out_ready so a result can retire and a new pair
  // can be accepted on the same edge.
  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);

  assign accept    = bus.in_valid && bus.in_ready;
  assign step      = (state == RUNNING);
  assign last_step = step && (cnt == CW'(W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) state <= RUNNING;
        end
        RUNNING: begin
          if (last_step) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt <= '0;
          if (bus.out_ready) state <= bus.in_valid ? RUNNING : IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  spm_datapath #(
    .W(W)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (step),
    .last_step (last_step),
    .mc        (bus.mc),
    .mp        (bus.mp),
    .is_signed (bus.is_signed),
    .p         (bus.p)
  );

endmodule
